// File: rtl/mem_fill_pkg.sv
// Shared state type, default parameters and width helper for the memory fill arbiter.
package mem_fill_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      TAG  = 2'd2
   } fill_state_t;

   localparam int DEF_N_CH          = 2;
   localparam int DEF_ADDR_W        = 16;
   localparam int DEF_DATA_W        = 16;
   localparam int DEF_WORDS_PER_BLK = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way request selector with a combinational grant; fixed priority (lowest index) by default,
// round-robin from a pointer register when MEM_FILL_RR_EN is defined.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
`ifdef MEM_FILL_RR_EN
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv_i,
`endif
   input  logic [N-1:0]     req_i,
   output logic             gnt_vld_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

`ifdef MEM_FILL_RR_EN
   logic [IDX_W-1:0] ptr_q;
   int               best_dist;

   // Winner is the requester closest to the pointer, walking upward with wrap.
   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      best_dist = N;
      for (int j = 0; j < N; j++) begin
         if (req_i[j] && (((j + N - int'(ptr_q)) % N) < best_dist)) begin
            best_dist = (j + N - int'(ptr_q)) % N;
            gnt_vld_o = 1'b1;
            gnt_idx_o = IDX_W'(j);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (adv_i && gnt_vld_o) begin
         ptr_q <= IDX_W'((int'(gnt_idx_o) + 1) % N);
      end
   end
`else
   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (req_i[j]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = IDX_W'(j);
         end
      end
   end
`endif

endmodule

// File: rtl/mem_fill_arbiter.sv
// Shares one memory port between N_CH caches: write-throughs issue from IDLE with priority, misses
// fetch a whole block (FILL) then write the tag (TAG). MEM_FILL_RR_EN selects round-robin arbitration.
module mem_fill_arbiter
   import mem_fill_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [N_CH-1:0]                  miss_req,
   input  logic [N_CH*ADDR_W-1:0]           miss_addr,
   input  logic [N_CH-1:0]                  wr_req,
   input  logic [N_CH*ADDR_W-1:0]           wr_addr,
   input  logic [N_CH*DATA_W-1:0]           wr_data,
   output logic [N_CH-1:0]                  busy,
   output logic [N_CH-1:0]                  wr_ack,
   output logic [N_CH-1:0]                  fill_we,
   output logic [N_CH-1:0]                  tag_we,
   output logic [clog2(WORDS_PER_BLK)-1:0]  fill_word,
   output logic [DATA_W-1:0]                fill_data,
   output logic                             mem_en,
   output logic                             mem_wr,
   output logic [ADDR_W-1:0]                mem_addr,
   output logic [DATA_W-1:0]                mem_wdata,
   input  logic [DATA_W-1:0]                mem_rdata,
   input  logic                             mem_valid
);

   localparam int WORD_W = clog2(WORDS_PER_BLK);
   localparam int CNT_W  = WORD_W + 1;
   localparam int IDX_W  = (N_CH > 1) ? clog2(N_CH) : 1;

   fill_state_t       state_q;
   logic [CNT_W-1:0]  issue_cnt_q, recv_cnt_q;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [IDX_W-1:0]  gidx_q;

   logic              w_vld, m_vld, wr_issue, miss_grant;
   logic [IDX_W-1:0]  w_idx, m_idx;

   logic [ADDR_W-1:0] miss_addr_a [N_CH];
   logic [ADDR_W-1:0] wr_addr_a   [N_CH];
   logic [DATA_W-1:0] wr_data_a   [N_CH];

   for (genvar c = 0; c < N_CH; c++) begin : g_unpack
      assign miss_addr_a[c] = miss_addr[c*ADDR_W +: ADDR_W];
      assign wr_addr_a[c]   = wr_addr[c*ADDR_W +: ADDR_W];
      assign wr_data_a[c]   = wr_data[c*DATA_W +: DATA_W];
   end

   function automatic logic [N_CH-1:0] ch_oh(input logic [IDX_W-1:0] i);
      return N_CH'(1) << i;
   endfunction

   rr_arbiter #(.N(N_CH), .IDX_W(IDX_W)) u_wr_arb (
`ifdef MEM_FILL_RR_EN
      .clk       (clk),
      .rst_n     (rst_n),
      .adv_i     (wr_issue),
`endif
      .req_i     (wr_req),
      .gnt_vld_o (w_vld),
      .gnt_idx_o (w_idx)
   );

   rr_arbiter #(.N(N_CH), .IDX_W(IDX_W)) u_miss_arb (
`ifdef MEM_FILL_RR_EN
      .clk       (clk),
      .rst_n     (rst_n),
      .adv_i     (miss_grant),
`endif
      .req_i     (miss_req),
      .gnt_vld_o (m_vld),
      .gnt_idx_o (m_idx)
   );

   assign wr_issue   = rst_n && (state_q == IDLE) && w_vld;
   assign miss_grant = rst_n && (state_q == IDLE) && !w_vld && m_vld;
   // Words are two bytes, so a block spans 2*WORDS_PER_BLK bytes.
   assign base_d     = miss_addr_a[m_idx] & ~ADDR_W'(2*WORDS_PER_BLK - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         base_q      <= '0;
         gidx_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (miss_grant) begin
                  state_q     <= FILL;
                  base_q      <= base_d;
                  gidx_q      <= m_idx;
                  issue_cnt_q <= '0;
                  recv_cnt_q  <= '0;
               end
            end
            FILL: begin
               if (issue_cnt_q < CNT_W'(WORDS_PER_BLK)) issue_cnt_q <= issue_cnt_q + 1'b1;
               if (mem_valid) begin
                  recv_cnt_q <= recv_cnt_q + 1'b1;
                  if (recv_cnt_q == CNT_W'(WORDS_PER_BLK - 1)) state_q <= TAG;
               end
            end
            TAG:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = '0;
      wr_ack    = '0;
      fill_we   = '0;
      tag_we    = '0;
      fill_word = '0;
      fill_data = '0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (rst_n) begin
         case (state_q)
            IDLE: begin
               if (w_vld) begin
                  mem_en    = 1'b1;
                  mem_wr    = 1'b1;
                  mem_addr  = wr_addr_a[w_idx];
                  mem_wdata = wr_data_a[w_idx];
                  wr_ack    = ch_oh(w_idx);
               end else if (m_vld) begin
                  busy = ch_oh(m_idx);
               end
            end
            FILL: begin
               busy = ch_oh(gidx_q);
               if (issue_cnt_q < CNT_W'(WORDS_PER_BLK)) begin
                  mem_en   = 1'b1;
                  mem_addr = base_q + ADDR_W'({issue_cnt_q, 1'b0});
               end
               if (mem_valid) begin
                  fill_we   = ch_oh(gidx_q);
                  fill_word = recv_cnt_q[WORD_W-1:0];
                  fill_data = mem_rdata;
               end
            end
            TAG: begin
               busy   = ch_oh(gidx_q);
               tag_we = ch_oh(gidx_q);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with an in-order, variable-latency memory model.
module tb_mem_fill_arbiter;

   logic        clk, rst_n;
   logic [1:0]  miss_req, wr_req, busy, wr_ack, fill_we, tag_we;
   logic [31:0] miss_addr, wr_addr, wr_data;
   logic [2:0]  fill_word;
   logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
   logic        mem_en, mem_wr, mem_valid;

   int pass_cnt = 0;
   int tot_cnt  = 0;

`ifdef MEM_FILL_RR_EN
   localparam logic [1:0] EXP_G1 = 2'b10;
`else
   localparam logic [1:0] EXP_G1 = 2'b01;
`endif

   mem_fill_arbiter dut (
      .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .wr_ack(wr_ack), .fill_we(fill_we), .tag_we(tag_we), .fill_word(fill_word),
      .fill_data(fill_data), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: reads return in order, data = addr ^ 0x5A5A.
   logic [15:0] mq_addr[$];
   int          mq_due[$];
   int          cyc = 0, last_due = 0, lat = 4, nd;
   bit          irregular = 0, inj_valid = 0, popping = 0;

   initial begin
      mem_valid = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #2;
         cyc++;
         if (popping) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end
         popping   = 0;
         mem_valid = 1'b0;
         mem_rdata = '0;
         if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
            last_due = 0;
         end else if (inj_valid) begin
            mem_valid = 1'b1;
            mem_rdata = 16'hDEAD;
         end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            mem_valid = 1'b1;
            mem_rdata = mq_addr[0] ^ 16'h5A5A;
            popping   = 1;
         end
         @(negedge clk);
         if (rst_n && mem_en && !mem_wr) begin
            nd = last_due + 1 + (irregular ? int'($urandom_range(0, 5)) : 0);
            if (nd < cyc + lat) nd = cyc + lat;
            last_due = nd;
            mq_addr.push_back(mem_addr);
            mq_due.push_back(nd);
         end
      end
   end

   // Fill observation results
   logic [15:0] w_iss[$];
   int          w_word[$];
   logic [15:0] w_data[$];
   int          w_first_iss, w_last_iss, w_tag_cnt, w_tag_cyc, w_last_fw, w_bad, w_wr_seen;
   logic [1:0]  a_busy, a_ack;
   logic        a_memwr;
   logic [15:0] a_addr, a_wdata;

   task automatic watch_fill(input int ch, input int budget);
      logic [1:0] oh;
      bit done;
      oh = 2'b01 << ch;
      w_iss.delete(); w_word.delete(); w_data.delete();
      w_first_iss = -1; w_last_iss = -1; w_tag_cnt = 0; w_tag_cyc = -1;
      w_last_fw = -1; w_bad = 0; w_wr_seen = 0;
      done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (mem_en && mem_wr) w_wr_seen++;
         if (mem_en && !mem_wr) begin
            w_iss.push_back(mem_addr);
            if (w_first_iss < 0) w_first_iss = i;
            w_last_iss = i;
         end
         if (fill_we != 2'b00) begin
            if (fill_we != oh) w_bad++;
            w_word.push_back(int'(fill_word));
            w_data.push_back(fill_data);
            w_last_fw = i;
         end
         if (tag_we != 2'b00) begin
            if (tag_we != oh) w_bad++;
            w_tag_cnt++;
            w_tag_cyc = i;
            done = 1;
         end
      end
      @(negedge clk);
      a_busy = busy; a_ack = wr_ack; a_memwr = mem_wr; a_addr = mem_addr; a_wdata = mem_wdata;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; miss_req = 2'b10; wr_req = 2'b01;
      miss_addr = {16'h1111, 16'h2222}; wr_addr = {16'h3333, 16'h4444}; wr_data = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tot_cnt++; if (busy !== 2'b00) $display("FAIL rst_busy got %b want 00", busy); else pass_cnt++;
      tot_cnt++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en got %b want 0", mem_en); else pass_cnt++;
      tot_cnt++; if (wr_ack !== 2'b00) $display("FAIL rst_wr_ack got %b want 00", wr_ack); else pass_cnt++;
      tot_cnt++; if (mem_addr !== 16'h0) $display("FAIL rst_mem_addr got %h want 0000", mem_addr); else pass_cnt++;
      tot_cnt++; if ({fill_we, tag_we, fill_word} !== 7'd0) $display("FAIL rst_fill got %b want 0", {fill_we, tag_we, fill_word}); else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1; wr_req = 2'b00; miss_req = 2'b00; inj_valid = 1;
      @(negedge clk);
      tot_cnt++; if (fill_we !== 2'b00) $display("FAIL idle_valid_ignored fill_we got %b want 00", fill_we); else pass_cnt++;
      tot_cnt++; if (fill_data !== 16'h0) $display("FAIL idle_fill_data got %h want 0000", fill_data); else pass_cnt++;
      @(posedge clk); #1;
      inj_valid = 0;
   endtask

   task automatic test_arbitration;
      logic [1:0] g0, g1, g2;
      @(posedge clk); #1;
      miss_addr = {16'h0200, 16'h0100}; miss_req = 2'b11;
      @(negedge clk);
      g0 = busy;
      watch_fill((g0 == 2'b10) ? 1 : 0, 100);
      tot_cnt++; if (w_tag_cnt !== 1) $display("FAIL arb_tag0 got %0d want 1", w_tag_cnt); else pass_cnt++;
      g1 = a_busy;
      watch_fill((g1 == 2'b10) ? 1 : 0, 100);
      tot_cnt++; if (w_iss.size() == 0 || w_iss[0] !== ((EXP_G1 == 2'b10) ? 16'h0200 : 16'h0100))
         $display("FAIL arb_base1 got %h want %h", (w_iss.size() > 0) ? w_iss[0] : 16'hxxxx, (EXP_G1 == 2'b10) ? 16'h0200 : 16'h0100);
      else pass_cnt++;
      g2 = a_busy;
      @(posedge clk); #1;
      miss_req = 2'b00;
      watch_fill((g2 == 2'b10) ? 1 : 0, 100);
      tot_cnt++; if (g0 !== 2'b01) $display("FAIL arb_grant0 got %b want 01", g0); else pass_cnt++;
      tot_cnt++; if (g1 !== EXP_G1) $display("FAIL arb_grant1 got %b want %b", g1, EXP_G1); else pass_cnt++;
      tot_cnt++; if (g2 !== 2'b01) $display("FAIL arb_grant2 got %b want 01", g2); else pass_cnt++;
      tot_cnt++; if (a_busy !== 2'b00) $display("FAIL arb_final_busy got %b want 00", a_busy); else pass_cnt++;
   endtask

   task automatic test_single_miss;
      @(posedge clk); #1;
      miss_addr = {16'h1236, 16'h0000}; miss_req = 2'b10;
      @(negedge clk);
      tot_cnt++; if (busy !== 2'b10) $display("FAIL single_grant_busy got %b want 10", busy); else pass_cnt++;
      @(posedge clk); #1;
      miss_req = 2'b00;
      watch_fill(1, 100);
      tot_cnt++; if (w_iss.size() != 8) $display("FAIL single_issue_cnt got %0d want 8", w_iss.size()); else pass_cnt++;
      tot_cnt++; if (w_first_iss != 0 || w_last_iss != 7) $display("FAIL single_issue_window got %0d..%0d want 0..7", w_first_iss, w_last_iss); else pass_cnt++;
      for (int k = 0; k < w_iss.size(); k++) begin
         tot_cnt++; if (w_iss[k] !== 16'h1230 + 16'(2*k)) $display("FAIL single_addr%0d got %h want %h", k, w_iss[k], 16'h1230 + 16'(2*k)); else pass_cnt++;
      end
      tot_cnt++; if (w_word.size() != 8) $display("FAIL single_fill_cnt got %0d want 8", w_word.size()); else pass_cnt++;
      for (int k = 0; k < w_word.size(); k++) begin
         tot_cnt++; if (w_word[k] != k) $display("FAIL single_word%0d got %0d want %0d", k, w_word[k], k); else pass_cnt++;
         tot_cnt++; if (w_data[k] !== ((16'h1230 + 16'(2*k)) ^ 16'h5A5A)) $display("FAIL single_data%0d got %h want %h", k, w_data[k], (16'h1230 + 16'(2*k)) ^ 16'h5A5A); else pass_cnt++;
      end
      tot_cnt++; if (w_bad != 0) $display("FAIL single_wrong_channel got %0d want 0", w_bad); else pass_cnt++;
      tot_cnt++; if (w_tag_cnt != 1) $display("FAIL single_tag_cnt got %0d want 1", w_tag_cnt); else pass_cnt++;
      tot_cnt++; if (w_tag_cyc != 12) $display("FAIL single_tag_cycle got %0d want 12", w_tag_cyc); else pass_cnt++;
      tot_cnt++; if (a_busy !== 2'b00) $display("FAIL single_busy_after got %b want 00", a_busy); else pass_cnt++;
   endtask

   task automatic test_write_priority;
      @(posedge clk); #1;
      wr_req = 2'b10; wr_addr = {16'h0040, 16'h0000}; wr_data = {16'hBEEF, 16'h0000};
      miss_req = 2'b01; miss_addr = {16'h0000, 16'h2000};
      @(negedge clk);
      tot_cnt++; if ({mem_en, mem_wr} !== 2'b11) $display("FAIL wp_strobes got %b want 11", {mem_en, mem_wr}); else pass_cnt++;
      tot_cnt++; if (mem_addr !== 16'h0040) $display("FAIL wp_addr got %h want 0040", mem_addr); else pass_cnt++;
      tot_cnt++; if (mem_wdata !== 16'hBEEF) $display("FAIL wp_wdata got %h want beef", mem_wdata); else pass_cnt++;
      tot_cnt++; if (wr_ack !== 2'b10) $display("FAIL wp_ack got %b want 10", wr_ack); else pass_cnt++;
      tot_cnt++; if (busy !== 2'b00) $display("FAIL wp_busy_in_write got %b want 00", busy); else pass_cnt++;
      @(posedge clk); #1;
      wr_req = 2'b00;
      @(negedge clk);
      tot_cnt++; if (busy !== 2'b01) $display("FAIL wp_fill_grant got %b want 01", busy); else pass_cnt++;
      tot_cnt++; if (wr_ack !== 2'b00) $display("FAIL wp_ack_single got %b want 00", wr_ack); else pass_cnt++;
      @(posedge clk); #1;
      miss_req = 2'b00;
      watch_fill(0, 100);
      tot_cnt++; if (w_word.size() != 8 || w_tag_cnt != 1) $display("FAIL wp_fill fills %0d tags %0d want 8 1", w_word.size(), w_tag_cnt); else pass_cnt++;
      tot_cnt++; if (w_iss.size() == 0 || w_iss[0] !== 16'h2000) $display("FAIL wp_fill_base got %h want 2000", (w_iss.size() > 0) ? w_iss[0] : 16'hxxxx); else pass_cnt++;
   endtask

   task automatic test_write_during_fill;
      @(posedge clk); #1;
      miss_addr = {16'h0000, 16'h0100}; miss_req = 2'b01;
      @(posedge clk); #1;
      miss_req = 2'b00;
      wr_req = 2'b01; wr_addr = {16'h0000, 16'h0300}; wr_data = {16'h0000, 16'h1234};
      watch_fill(0, 100);
      tot_cnt++; if (w_wr_seen != 0) $display("FAIL wdf_write_leaked got %0d want 0", w_wr_seen); else pass_cnt++;
      tot_cnt++; if (w_tag_cnt != 1) $display("FAIL wdf_tag_cnt got %0d want 1", w_tag_cnt); else pass_cnt++;
      tot_cnt++; if (a_ack !== 2'b01) $display("FAIL wdf_ack got %b want 01", a_ack); else pass_cnt++;
      tot_cnt++; if (a_memwr !== 1'b1 || a_addr !== 16'h0300 || a_wdata !== 16'h1234)
         $display("FAIL wdf_write got wr=%b addr=%h data=%h want 1 0300 1234", a_memwr, a_addr, a_wdata);
      else pass_cnt++;
      @(posedge clk); #1;
      wr_req = 2'b00;
      @(negedge clk);
      tot_cnt++; if (wr_ack !== 2'b00) $display("FAIL wdf_ack_pulse got %b want 00", wr_ack); else pass_cnt++;
   endtask

   task automatic test_reset_mid_fill;
      int n, tags;
      @(posedge clk); #1;
      miss_addr = {16'h0456, 16'h0000}; miss_req = 2'b10;
      @(posedge clk); #1;
      miss_req = 2'b00;
      n = 0;
      for (int i = 0; i < 50 && n < 3; i++) begin
         @(negedge clk);
         if (fill_we != 2'b00) n++;
      end
      tot_cnt++; if (n != 3) $display("FAIL rmf_pre_fills got %0d want 3", n); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      tot_cnt++; if ({busy, fill_we, tag_we} !== 6'd0) $display("FAIL rmf_async_idle got %b want 0", {busy, fill_we, tag_we}); else pass_cnt++;
      tot_cnt++; if ({mem_en, mem_wr, mem_addr} !== 18'd0) $display("FAIL rmf_async_mem got %h want 0", {mem_en, mem_wr, mem_addr}); else pass_cnt++;
      tot_cnt++; if ({fill_word, fill_data} !== 19'd0) $display("FAIL rmf_async_fill got %h want 0", {fill_word, fill_data}); else pass_cnt++;
      tags = 0;
      miss_req = 2'b10;
      repeat (3) begin
         @(negedge clk);
         if (tag_we != 2'b00) tags++;
      end
      tot_cnt++; if (tags != 0) $display("FAIL rmf_no_tag got %0d want 0", tags); else pass_cnt++;
      tot_cnt++; if (busy !== 2'b00) $display("FAIL rmf_no_grant_in_reset got %b want 00", busy); else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      tot_cnt++; if (busy !== 2'b10) $display("FAIL rmf_regrant got %b want 10", busy); else pass_cnt++;
      @(posedge clk); #1;
      miss_req = 2'b00;
      watch_fill(1, 100);
      tot_cnt++; if (w_word.size() != 8 || w_tag_cnt != 1) $display("FAIL rmf_refill fills %0d tags %0d want 8 1", w_word.size(), w_tag_cnt); else pass_cnt++;
      tot_cnt++; if (w_word.size() == 0 || w_word[0] != 0) $display("FAIL rmf_first_word got %0d want 0", (w_word.size() > 0) ? w_word[0] : -1); else pass_cnt++;
      tot_cnt++; if (w_iss.size() == 0 || w_iss[0] !== 16'h0450) $display("FAIL rmf_base got %h want 0450", (w_iss.size() > 0) ? w_iss[0] : 16'hxxxx); else pass_cnt++;
   endtask

   task automatic test_irregular_latency;
      irregular = 1;
      @(posedge clk); #1;
      miss_addr = {16'h0000, 16'hFFFA}; miss_req = 2'b01;
      @(posedge clk); #1;
      miss_req = 2'b00;
      watch_fill(0, 300);
      tot_cnt++; if (w_word.size() != 8) $display("FAIL irr_fill_cnt got %0d want 8", w_word.size()); else pass_cnt++;
      for (int k = 0; k < w_word.size(); k++) begin
         tot_cnt++; if (w_word[k] != k || w_data[k] !== ((16'hFFF0 + 16'(2*k)) ^ 16'h5A5A))
            $display("FAIL irr_word%0d got %0d/%h want %0d/%h", k, w_word[k], w_data[k], k, (16'hFFF0 + 16'(2*k)) ^ 16'h5A5A);
         else pass_cnt++;
      end
      tot_cnt++; if (w_tag_cnt != 1) $display("FAIL irr_tag_cnt got %0d want 1", w_tag_cnt); else pass_cnt++;
      tot_cnt++; if (w_bad != 0) $display("FAIL irr_wrong_channel got %0d want 0", w_bad); else pass_cnt++;
      tot_cnt++; if (w_iss.size() != 8 || w_iss[7] !== 16'hFFFE) $display("FAIL irr_last_addr got %h want fffe", (w_iss.size() == 8) ? w_iss[7] : 16'hxxxx); else pass_cnt++;
      irregular = 0;
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_single_miss();
      test_write_priority();
      test_write_during_fill();
      test_reset_mid_fill();
      test_irregular_latency();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/mem_fill_arbiter.md
MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

Interface
REQ-001 Parameter N_CH, default 2; number of cache channels sharing main memory (ch0 = I-cache, ch1 = D-cache), legal range 1..8.
REQ-002 Parameter ADDR_W, default 16; byte address width.
REQ-003 Parameter DATA_W, default 16; word width.
REQ-004 Parameter WORDS_PER_BLK, default 8; words per cache block, power of two, legal range 2..64.
REQ-005 clk  in  1  system clock, all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 miss_req  in  N_CH  per-channel miss, held while that channel is stalled.
REQ-008 miss_addr  in  N_CH*ADDR_W  per-channel miss byte address, packed with ch0 in the LSBs.
REQ-009 wr_req  in  N_CH  per-channel write-through request.
REQ-010 wr_addr  in  N_CH*ADDR_W  per-channel write address.
REQ-011 wr_data  in  N_CH*DATA_W  per-channel write data.
REQ-012 busy  out  N_CH  channel's miss is granted and its fill is not yet complete.
REQ-013 wr_ack  out  N_CH  one-cycle pulse when the channel's write is issued to memory.
REQ-014 fill_we  out  N_CH  write the data array of the granted channel.
REQ-015 tag_we  out  N_CH  write the tag array of the granted channel.
REQ-016 fill_word  out  log2(WORDS_PER_BLK)  word index within the block for fill_we.
REQ-017 fill_data  out  DATA_W  word to write into the cache.
REQ-018 mem_en, mem_wr  out  1 each  main-memory enable and write strobes.
REQ-019 mem_addr  out  ADDR_W  and mem_wdata  out  DATA_W  main-memory address and write data.
REQ-020 mem_rdata  in  DATA_W  and mem_valid  in  1  main-memory read data and its qualifier; read latency is arbitrary, and reads return in issue order.

Function
REQ-021 The FSM states SHALL be IDLE, FILL and TAG.
REQ-022 In IDLE, any wr_req SHALL take priority over every miss_req.
  - The selected write drives mem_en=1, mem_wr=1, mem_addr and mem_wdata in that same cycle.
  - The matching wr_ack pulses in that same cycle.
  - The state remains IDLE; one write is issued per cycle.
REQ-023 In IDLE with no wr_req and any miss_req, the arbiter SHALL grant one channel, latch its block base and go to FILL next cycle.
  - Block base = miss_addr with the low log2(WORDS_PER_BLK)+1 bits cleared.
  - The granted channel's busy asserts combinationally in the grant cycle.
REQ-024 In FILL, mem_en=1 and mem_wr=0 SHALL be driven with mem_addr = base + 2*issue_cnt while issue_cnt < WORDS_PER_BLK; issue_cnt increments once per issued cycle.
REQ-025 In the cycle mem_valid=1 in FILL, the arbiter SHALL do the following.
  - Assert fill_we for the granted channel only.
  - Drive fill_word = recv_cnt and fill_data = mem_rdata.
  - Increment recv_cnt.
REQ-026 After the valid with recv_cnt = WORDS_PER_BLK-1, the state SHALL become TAG.
  - tag_we for the granted channel asserts for exactly one cycle.
  - The state then returns to IDLE and busy deasserts.
REQ-027 wr_req arriving during FILL or TAG SHALL wait until IDLE; it is not dropped.
REQ-028 A miss_req deasserting mid-fill SHALL NOT abort the fill.
REQ-029 mem_valid in IDLE SHALL be ignored.
REQ-030 Counters SHALL be log2(WORDS_PER_BLK)+1 bits wide so that they never wrap.
REQ-031 Address arithmetic SHALL be modulo 2^ADDR_W.
REQ-032 When idle, outputs SHALL be: mem_en=0, mem_wr=0, fill_we=0, tag_we=0, wr_ack=0, mem_addr=0, mem_wdata=0, fill_word=0 and fill_data=0.

Reset
REQ-033 While rst_n=0, the following SHALL hold asynchronously.
  - State = IDLE.
  - issue_cnt, recv_cnt, base and grant index = 0.
  - Round-robin pointer = 0.
  - All outputs at their idle values.
REQ-034 Reset asserted mid-fill SHALL abort the fill with no tag_we.
REQ-035 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-036 Macro MEM_FILL_RR_EN SHALL select the arbitration scheme for both miss and write selection.
  - Defined: round-robin. The pointer advances to grant index+1 (mod N_CH) after each grant; the search starts at the pointer.
  - Undefined: fixed priority, lowest channel index wins; no pointer state is synthesised.

Structure
REQ-037 Package mem_fill_pkg SHALL hold the following.
  - The state enum (IDLE, FILL, TAG).
  - Default parameter constants.
  - A clog2 helper function.
REQ-038 Sub-module rr_arbiter (N-way; fixed priority or round-robin per REQ-036; combinational grant plus pointer register) SHALL be instantiated separately for miss selection and for write selection.

Verification
REQ-039 Single miss: ch1 miss_addr=0x1236 with memory latency 4 -> the fill behaves as follows.
  - mem_addr = 0x1230..0x123E over 8 consecutive cycles.
  - 8 fill_we[1] pulses with fill_word 0..7.
  - One tag_we[1] in the cycle after the last valid.
  - busy[1] deasserts after that.
REQ-040 Write priority: in the same cycle, wr_req[1] (addr 0x0040, data 0xBEEF) and miss_req[0] -> the write goes first, then the fill.
  - mem_wr=1 with addr 0x0040 and data 0xBEEF.
  - wr_ack[1] pulses in that cycle.
  - The ch0 fill is granted in the following cycle.
REQ-041 Arbitration: miss_req=2'b11 held, repeated -> the grant order depends on the macro.
  - With MEM_FILL_RR_EN: grants alternate ch0, ch1, ch0.
  - Without it: ch0 wins every time it requests.
REQ-042 Write during fill: wr_req[0] asserted in FILL -> the write waits.
  - No mem_wr until IDLE.
  - wr_ack[0] pulses in the first IDLE cycle after TAG.
REQ-043 Reset mid-fill: rst_n=0 after the 3rd fill_we -> immediate return to idle.
  - All outputs reach idle values immediately, with no tag_we.
  - After release, a new miss fills from word 0.
REQ-044 Irregular latency: mem_valid gaps of 0..5 cycles -> the fill still completes.
  - Exactly WORDS_PER_BLK fill_we pulses in order.
  - Exactly one tag_we.
